// File: rtl/conversor_pkg.sv
// Shared types and 7-segment patterns for the binary-to-two-digit display path.
package conversor_pkg;

  typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}, active-low

  localparam int NUM_DIG = 2;   // lane 0 = tens, lane 1 = units
  localparam int DIG_W   = 4;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0011000   // 9 (segment d off)
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module seg7_decoder
  import conversor_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  input  logic             blank,
  output seg7_t            seg
);

  // Codes above 9 cannot arrive from the splitter; they still decode to blank.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9)
      seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/conversor_bdc.sv
// 4-bit switch value -> tens/units 7-segment patterns, registered once.
module conversor_bdc
  import conversor_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  switches,
  output logic [13:0] display
);

  // Flipping every bit turns the active-low patterns into active-high ones.
  localparam logic [13:0] INV_MASK   = SEG_ACTIVE_LOW ? 14'h0000 : 14'h3fff;
  localparam logic [13:0] DISP_BLANK = {SEG_BLANK, SEG_BLANK} ^ INV_MASK;

  logic                           ge10;
  logic [NUM_DIG-1:0][DIG_W-1:0]  dig;
  logic [NUM_DIG-1:0]             blk;
  seg7_t [NUM_DIG-1:0]            seg;
  logic [13:0]                    disp_d;

  // Compare-and-subtract-10 split; a 4-bit value has at most one ten.
  always_comb begin
    ge10   = (switches >= 4'd10);
    dig[1] = ge10 ? (switches - 4'd10) : switches;
    blk[1] = 1'b0;
    dig[0] = {3'b000, ge10};
    blk[0] = ~ge10;  // leading zero suppressed
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      seg7_decoder u_dec (
        .digit (dig[g]),
        .blank (blk[g]),
        .seg   (seg[g])
      );
    end
  endgenerate

  // seg[1] (units) lands in display[13:7], seg[0] (tens) in display[6:0].
  assign disp_d = seg ^ INV_MASK;

  // Output register; reset wins over the sampled switches.
  always_ff @(posedge clk) begin
    if (rst) display <= DISP_BLANK;
    else     display <= disp_d;
  end

endmodule

// File: tb/tb_conversor_bdc.sv
// Self-checking bench for conversor_bdc: directed table, corner sequences, random.
module tb_conversor_bdc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  switches;
  logic [13:0] display;

  int n_cmp = 0;
  int n_bad = 0;

  conversor_bdc #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .display  (display)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r;
    logic [3:0]  sw;
    logic [13:0] exp;
  } vec_t;

  // Reference: decimal digits by plain arithmetic, looked up in the display chart.
  function automatic logic [6:0] glyph(int d);
    logic [6:0] chart [0:9];
    chart = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    return chart[d];
  endfunction

  function automatic logic [13:0] model(logic r, int v);
    int u, t;
    if (r) return 14'h3fff;
    u = v % 10;
    t = v / 10;
    return {glyph(u), (t == 0) ? 7'b1111111 : glyph(t)};
  endfunction

  task automatic check(string name, logic [13:0] exp);
    n_cmp++;
    if (display !== exp) begin
      n_bad++;
      $display("FAIL %s: display=%b expected=%b", name, display, exp);
    end
  endtask

  // Drive away from the edge, clock once, sample 1 time unit later.
  task automatic step(logic r, logic [3:0] sw);
    rst = r;
    switches = sw;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [$];

  initial begin
    rst = 1'b1;
    switches = 4'b0000;
    #2;

    tbl = '{
      '{"reset_1",   1'b1, 4'b0101, 14'b11111111111111},
      '{"reset_2",   1'b1, 4'b0101, 14'b11111111111111},
      '{"val_7",     1'b0, 4'b0111, 14'b11110001111111},
      '{"val_9",     1'b0, 4'b1001, 14'b00110001111111},
      '{"val_12",    1'b0, 4'b1100, 14'b01001001111001},
      '{"val_3",     1'b0, 4'b0011, 14'b01100001111111},
      '{"bnd_10",    1'b0, 4'b1010, 14'b10000001111001},
      '{"bnd_15",    1'b0, 4'b1111, 14'b00100101111001},
      '{"bnd_0",     1'b0, 4'b0000, 14'b10000001111111},
      '{"mid_rst",   1'b1, 4'b1110, 14'b11111111111111},
      '{"post_rst",  1'b0, 4'b1110, 14'b00110011111001}
    };
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].sw);
      check(tbl[i].name, tbl[i].exp);
    end

    // Sweep: each value shows exactly one edge after it is applied.
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 4'(v));
      check($sformatf("sweep_%0d", v), model(1'b0, v));
    end

    // Latency: input change between edges must not leak to the output.
    step(1'b0, 4'd8);
    switches = 4'd1;
    #3;
    check("hold_between_edges", model(1'b0, 8));
    @(posedge clk);
    #1;
    check("after_edge", model(1'b0, 1));

    // Reset held over changing input keeps blank, then releases on value.
    step(1'b1, 4'd13);
    check("rst_hold_a", 14'h3fff);
    step(1'b1, 4'd4);
    check("rst_hold_b", 14'h3fff);
    step(1'b0, 4'd4);
    check("rst_release", model(1'b0, 4));

    // Random stream with sporadic resets.
    for (int k = 0; k < 300; k++) begin
      logic       r;
      logic [3:0] s;
      r = ($urandom_range(0, 15) == 0);
      s = 4'($urandom_range(0, 15));
      step(r, s);
      check($sformatf("rand_%0d_r%0d_v%0d", k, r, s), model(r, int'(s)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conversor_bdc.md
Name: conversor_bdc

Overview:
- Converts a 4-bit binary value from board switches (0–15) into two decimal digits and drives them as two active-low 7-segment patterns.
- Sits between the switch inputs and the board's two-digit 7-segment display.
- The tens digit is blanked when the value is below 10.
- Output is registered: one clock of latency.

Parameters:
- SEG_ACTIVE_LOW, default 1: 1 means a lit segment is 0 (common-anode), and blank is all 1s. 0 inverts every output bit, so blank is all 0s.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- switches  input  4  unsigned binary value, 0–15
- display  output  14  display[13:7] = units digit pattern; display[6:0] = tens digit pattern. Each 7-bit field is ordered {g,f,e,d,c,b,a}, with bit 0 = segment a.

Behaviour:
- Reset:
  - Synchronous, active-high. On a clk edge with rst=1, display <= 14'b11111111111111, so both digits are blank (with SEG_ACTIVE_LOW=1).
  - Reset has priority over new input.
- Latency:
  - display updates on every rising clk edge with rst=0, from the switches value sampled at that edge.
  - Latency is exactly 1 cycle; there is no handshake.
- Digit split:
  - units = switches mod 10; tens = switches >= 10 ? 1 : 0.
  - Implement with a compare-and-subtract-10 on 4 bits (no divider).
  - Widths: the units result fits in 4 bits; the tens result fits in 1 bit.
- Units encoding ({g..a}, active-low):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0011000 (segment d off)
- Tens encoding:
  - tens = 0 drives blank, 1111111 (leading zero suppressed).
  - tens = 1 drives 1111001.
- Boundaries:
  - 9 -> tens blank.
  - 10 -> tens "1", units "0".
  - 15 -> tens "1", units "5".
  - Every 4-bit input is legal; there is no error state.
- Decoder default branch (unreachable digit codes 10–15 at the decoder input) outputs blank.
- switches is treated as synchronous to clk; synchronizing it is the integrator's responsibility.

Decomposition:
- Shared package conversor_pkg:
  - typedef seg7_t (logic [6:0])
  - constant SEG_BLANK
  - constant array SEG_DIGIT[0:9] holding the patterns above
- One sub-module, seg7_decoder:
  - input: 4-bit digit plus a blank flag
  - output: seg7_t
  - purely combinational
  - instantiated twice, once for units and once for tens
- Top level contains the digit split, both decoder instances, the SEG_ACTIVE_LOW inversion and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with switches=4'b0101 -> display == 14'b11111111111111 after the first edge; stays blank while rst is held.
- Value 7: rst=0, switches=4'b0111 -> one edge later, display == 14'b11110001111111.
- Value 9: switches=4'b1001 -> display == 14'b00110001111111.
- Value 12: switches=4'b1100 -> display == 14'b01001001111001.
- Value 3 then sweep: switches=4'b0011 -> display == 14'b01100001111111. Then sweep 0..15, checking each output one cycle after its input. Boundaries: 10 -> 14'b10000001111001; 15 -> 14'b00100101111001; 0 -> 14'b10000001111111.
- Reset mid-stream: switches=4'b1110 and rst asserted on the same edge -> display blank; value 14 (14'b00110011111001) appears one cycle after rst deasserts.
